// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: reads program memory at the PC, hands each word to the
// decoder over valid/ready, then steps or branches the PC; stops for good after PC wrap.
module instr_fetch #(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 8,
    parameter int MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [ADDR_W-1:0]  pc_val,
    input  logic               pc_max_reached,
    output logic               pc_inc,
    output logic [ADDR_W-1:0]  pc_inc_val,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               branch_en,
    input  logic [ADDR_W-1:0]  branch_off,
    output logic               halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_ADV,
        S_HALT
    } state_t;

    localparam logic [1:0] WAIT_LAST = 2'(MEM_LAT - 1);

    state_t              r_state;
    logic [1:0]          r_wait_cnt;
    logic                r_pc_inc;
    logic [ADDR_W-1:0]   r_pc_inc_val;
    logic [INSTR_W-1:0]  r_instr;
    logic                r_instr_valid;
    logic                r_halted;
    logic                w_handshake;
    logic                w_mem_rd;

    // The wrap flag only becomes visible in REQ itself, so the read strobe is gated here
    // rather than registered; otherwise a read would leak out on the halting REQ.
    assign w_mem_rd    = (r_state == S_REQ) && !pc_max_reached;
    assign w_handshake = r_instr_valid && instr_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= '0;
            r_pc_inc      <= 1'b0;
            r_pc_inc_val  <= ADDR_W'(1);
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_pc_inc <= 1'b0;
            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ: begin
                    if (pc_max_reached) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == WAIT_LAST) begin
                        r_instr       <= mem_rdata;
                        r_instr_valid <= 1'b1;
                        r_wait_cnt    <= '0;
                        r_state       <= S_HOLD;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 2'd1;
                    end
                end
                S_HOLD: begin
                    if (w_handshake) begin
                        r_instr_valid <= 1'b0;
                        r_pc_inc      <= 1'b1;
                        r_pc_inc_val  <= branch_en ? branch_off : ADDR_W'(1);
                        r_state       <= S_ADV;
                    end
                end
                S_ADV:  r_state <= S_REQ;
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pc_inc      = r_pc_inc;
    assign pc_inc_val  = r_pc_inc_val;
    assign mem_rd      = w_mem_rd;
    assign mem_addr    = pc_val;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign halted      = r_halted;

endmodule
